// File: rtl/ecc_pkg.sv
// SECDED codeword layout, scrubber state encoding and Hamming helpers shared by
// the scrubber and the existing encoder/decoder.
package ecc_pkg;

    localparam int unsigned DATA_W = 11;
    localparam int unsigned PAR_W  = 5;
    localparam int unsigned CW_W   = 16;

    typedef struct packed {
        logic [PAR_W-1:0]  parity;
        logic [DATA_W-1:0] data;
    } codeword_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD_REQ,
        S_RD_DATA,
        S_CHECK,
        S_WR_REQ,
        S_NEXT
    } scrub_state_t;

    // Hamming position of data bit k; positions 1,2,4,8 belong to check bits
    function automatic logic [3:0] data_pos(input int unsigned k);
        case (k)
            0:       data_pos = 4'd3;
            1:       data_pos = 4'd5;
            2:       data_pos = 4'd6;
            3:       data_pos = 4'd7;
            4:       data_pos = 4'd9;
            5:       data_pos = 4'd10;
            6:       data_pos = 4'd11;
            7:       data_pos = 4'd12;
            8:       data_pos = 4'd13;
            9:       data_pos = 4'd14;
            default: data_pos = 4'd15;
        endcase
    endfunction

    // Check bits equal the XOR of the positions of all set data bits
    function automatic logic [3:0] hamming_par(input logic [DATA_W-1:0] d);
        logic [3:0] p;
        p = 4'd0;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            if (d[4'(k)]) p = p ^ data_pos(k);
        end
        return p;
    endfunction

endpackage

// File: rtl/secded_dec.sv
// SECDED decoder: corrects any single-bit error, flags double-bit errors.
module secded_dec
    import ecc_pkg::*;
(
    input  codeword_t         codeword,
    output logic [DATA_W-1:0] data_corrected,
    output logic              double_error_flag
);

    logic [3:0] syndrome;
    logic       overall;

    assign syndrome          = hamming_par(codeword.data) ^ codeword.parity[3:0];
    assign overall           = ^codeword;
    assign double_error_flag = (syndrome != 4'd0) && !overall;

    always_comb begin
        data_corrected = codeword.data;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            if (overall && (syndrome == data_pos(k))) begin
                data_corrected[4'(k)] = ~codeword.data[4'(k)];
            end
        end
    end

endmodule

// File: rtl/secded_enc.sv
// SECDED encoder: 11 data bits -> {overall parity, 4 Hamming check bits}.
module secded_enc
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    output logic [PAR_W-1:0]  parity
);

    logic [3:0] ham;

    assign ham    = hamming_par(data_in);
    assign parity = {^{data_in, ham}, ham};

endmodule

// File: rtl/ecc_scrubber.sv
// Background scrubber: walks the SECDED array, writes back correctable words,
// logs uncorrectable ones, and yields to core writes to the word in flight.
module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned INTERVAL = 1024,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scrub_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [CW_W-1:0]  mem_wdata,
    input  logic             mem_grant,
    input  logic [CW_W-1:0]  mem_rdata,
    input  logic             cpu_wr_valid,
    input  logic [AW-1:0]    cpu_wr_addr,
    output logic             busy,
    output logic             pass_done,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count,
    output logic             uncorr_valid,
    output logic [AW-1:0]    uncorr_addr
);

    localparam int unsigned IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    scrub_state_t     state_q;
    logic [IW-1:0]    ivl_q;
    logic [AW-1:0]    addr_q;
    codeword_t        word_q;
    logic             snoop_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [CW_W-1:0]  mem_wdata_q;
    logic             busy_q;
    logic             pass_done_q;
    logic [CNT_W-1:0] corr_q;
    logic [CNT_W-1:0] uncorr_q;
    logic             uncorr_valid_q;
    logic [AW-1:0]    uncorr_addr_q;

    logic [DATA_W-1:0] data_fix_c;
    logic [PAR_W-1:0]  enc_par_c;
    logic              dbl_err_c;
    codeword_t         fixed_cw_c;
    logic              fix_needed_c;
    logic              snoop_c;
    logic              last_addr_c;

    secded_dec u_dec (
        .codeword          (word_q),
        .data_corrected    (data_fix_c),
        .double_error_flag (dbl_err_c)
    );

    secded_enc u_enc (
        .data_in (data_fix_c),
        .parity  (enc_par_c)
    );

    assign fixed_cw_c   = {enc_par_c, data_fix_c};
    assign fix_needed_c = (fixed_cw_c != word_q);
    assign snoop_c      = cpu_wr_valid && (cpu_wr_addr == addr_q);
    assign last_addr_c  = (addr_q == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ivl_q          <= '0;
            addr_q         <= '0;
            word_q         <= '0;
            snoop_q        <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= '0;
            busy_q         <= 1'b0;
            pass_done_q    <= 1'b0;
            corr_q         <= '0;
            uncorr_q       <= '0;
            uncorr_valid_q <= 1'b0;
            uncorr_addr_q  <= '0;
        end else begin
            pass_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (scrub_en) begin
                        state_q <= S_WAIT;
                        ivl_q   <= IW'(INTERVAL - 1);
                    end
                end
                S_WAIT: begin
                    if (!scrub_en) begin
                        state_q <= S_IDLE;
                    end else if (ivl_q == '0) begin
                        state_q   <= S_RD_REQ;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        ivl_q <= ivl_q - IW'(1);
                    end
                end
                S_RD_REQ: begin
                    if (mem_grant) begin
                        state_q   <= S_RD_DATA;
                        mem_req_q <= 1'b0;
                    end
                end
                S_RD_DATA: begin
                    word_q  <= mem_rdata;
                    snoop_q <= snoop_c;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    snoop_q <= snoop_q | snoop_c;
                    state_q <= S_NEXT;
                    if (dbl_err_c) begin
                        if (uncorr_q != '1) uncorr_q <= uncorr_q + CNT_W'(1);
                        uncorr_valid_q <= 1'b1;
                        uncorr_addr_q  <= addr_q;
                    end else if (fix_needed_c) begin
                        if (corr_q != '1) corr_q <= corr_q + CNT_W'(1);
                        // A core write already replaced this word: never issue the stale write-back
                        if (!(snoop_q || snoop_c)) begin
                            state_q     <= S_WR_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= fixed_cw_c;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (mem_grant || snoop_c) begin
                        state_q   <= S_NEXT;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                S_NEXT: begin
                    addr_q      <= last_addr_c ? '0 : addr_q + AW'(1);
                    pass_done_q <= last_addr_c;
                    busy_q      <= 1'b0;
                    if (scrub_en) begin
                        state_q <= S_WAIT;
                        ivl_q   <= IW'(INTERVAL - 1);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign pass_done    = pass_done_q;
    assign corr_count   = corr_q;
    assign uncorr_count = uncorr_q;
    assign uncorr_valid = uncorr_valid_q;
    assign uncorr_addr  = uncorr_addr_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Scoreboard bench for ecc_scrubber: storage model, random grants and error
// injection, expected write-backs/reads queued from a SECDED reference model.
module tb_ecc_scrubber;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AW       = 2;
    localparam int unsigned INTERVAL = 2;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             scrub_en = 1'b0;
    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [15:0]      mem_wdata;
    logic             mem_grant = 1'b0;
    logic [15:0]      mem_rdata = 16'h0;
    logic             cpu_wr_valid = 1'b0;
    logic [AW-1:0]    cpu_wr_addr = '0;
    logic             busy;
    logic             pass_done;
    logic [CNT_W-1:0] corr_count;
    logic [CNT_W-1:0] uncorr_count;
    logic             uncorr_valid;
    logic [AW-1:0]    uncorr_addr;

    ecc_scrubber #(.DEPTH(DEPTH), .INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scrub_en     (scrub_en),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_grant    (mem_grant),
        .mem_rdata    (mem_rdata),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_addr  (cpu_wr_addr),
        .busy         (busy),
        .pass_done    (pass_done),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count),
        .uncorr_valid (uncorr_valid),
        .uncorr_addr  (uncorr_addr)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [15:0]      mem    [DEPTH];
    logic [15:0]      golden [DEPTH];
    logic [AW+15:0]   exp_wr_q [$];
    logic [AW+15:0]   wr_item;
    logic [AW-1:0]    exp_rd_addr = '0;
    int               pass_cnt = 0;
    int               rd_in_pass = 0;
    int               exp_corr = 0;
    int               exp_unc = 0;
    logic             exp_uv = 1'b0;
    logic [AW-1:0]    exp_ua = '0;
    bit               block_all = 1'b0;
    bit               block_wr = 1'b0;
    int unsigned      gnt_pct = 100;
    logic             prev_req = 1'b0;
    logic             prev_gnt = 1'b0;
    logic             prev_we = 1'b0;
    logic [AW-1:0]    prev_addr = '0;
    logic [15:0]      prev_wdata = 16'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Classic Hamming(15,11) placement plus an overall parity bit on top
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] v;
        logic [3:0]  par;
        int          di;
        v   = 16'h0;
        par = 4'h0;
        di  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                v[4'(pos)] = d[4'(di)];
                di++;
            end
        end
        for (int p = 0; p < 4; p++)
            for (int pos = 1; pos < 16; pos++)
                if (((pos >> p) & 1) == 1) par[2'(p)] = par[2'(p)] ^ v[4'(pos)];
        return {^{d, par}, par, d};
    endfunction

    function automatic logic [15:0] flips(input int n);
        logic [15:0] m;
        m = 16'h0;
        while ($countones(m) < n) m[4'($urandom_range(0, 15))] = 1'b1;
        return m;
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CNT_MAX) ? c : c + 1;
    endfunction

    // Expected outcome of one full pass, from the error weight of each stored word
    task automatic plan_pass();
        rd_in_pass = 0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            case ($countones(mem[a] ^ golden[a]))
                0: ;
                1: begin
                    exp_wr_q.push_back({AW'(a), golden[a]});
                    exp_corr = sat_inc(exp_corr);
                end
                default: begin
                    exp_unc = sat_inc(exp_unc);
                    exp_uv  = 1'b1;
                    exp_ua  = AW'(a);
                end
            endcase
        end
    endtask

    task automatic wait_pass(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            if (pass_done) seen = 1'b1;
        end
        #1;
        check({tag, "_pass_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_end(input string tag);
        check({tag, "_corr_count"},   32'(corr_count),   32'(exp_corr));
        check({tag, "_uncorr_count"}, 32'(uncorr_count), 32'(exp_unc));
        check({tag, "_uncorr_valid"}, 32'(uncorr_valid), 32'(exp_uv));
        if (exp_uv) check({tag, "_uncorr_addr"}, 32'(uncorr_addr), 32'(exp_ua));
        check({tag, "_writes_left"},  32'(exp_wr_q.size()), 32'd0);
        check({tag, "_reads"},        32'(rd_in_pass), 32'(DEPTH));
    endtask

    task automatic wait_write(input string tag, input logic [AW-1:0] addr);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (mem_req && mem_we) seen = 1'b1;
        end
        check({tag, "_wr_req_seen"}, 32'(seen), 32'd1);
        check({tag, "_wr_req_addr"}, 32'(mem_addr), 32'(addr));
    endtask

    // Arbiter: random grants, optionally withheld for all or for writes only
    always @(posedge clk) begin
        #1;
        if (block_all || (block_wr && mem_we)) mem_grant = 1'b0;
        else mem_grant = ($urandom_range(0, 99) < gnt_pct);
    end

    // Storage model and monitor: serves reads, pops expected write-backs
    always @(negedge clk) begin
        if (!rst_n) exp_rd_addr = '0;
        if (pass_done) pass_cnt++;
        if (prev_req && !prev_gnt && mem_req) begin
            check("hold_addr",  32'(mem_addr),  32'(prev_addr));
            check("hold_we",    32'(mem_we),    32'(prev_we));
            check("hold_wdata", 32'(mem_wdata), 32'(prev_wdata));
        end
        if (mem_req && mem_grant) begin
            if (mem_we) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_expected", 32'(exp_wr_q.size()), 32'd1);
                end else begin
                    wr_item = exp_wr_q.pop_front();
                    check("wr_addr", 32'(mem_addr),  32'(wr_item[AW+15:16]));
                    check("wr_data", 32'(mem_wdata), 32'(wr_item[15:0]));
                end
                mem[mem_addr] = mem_wdata;
            end else begin
                check("rd_addr", 32'(mem_addr), 32'(exp_rd_addr));
                mem_rdata   = mem[mem_addr];
                exp_rd_addr = (exp_rd_addr == AW'(DEPTH - 1)) ? '0 : exp_rd_addr + AW'(1);
                rd_in_pass++;
            end
        end
        prev_req   = mem_req;
        prev_gnt   = mem_grant;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < int'(DEPTH); a++) begin
            golden[a] = encode(11'($urandom));
            mem[a]    = golden[a];
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem_req",      32'(mem_req),      32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_pass_done",    32'(pass_done),    32'd0);
        check("rst_corr_count",   32'(corr_count),   32'd0);
        check("rst_uncorr_count", 32'(uncorr_count), 32'd0);
        check("rst_uncorr_valid", 32'(uncorr_valid), 32'd0);
        check("rst_uncorr_addr",  32'(uncorr_addr),  32'd0);

        // Clean array, grant always high
        gnt_pct = 100;
        plan_pass();
        scrub_en = 1'b1;
        wait_pass("t1");
        check_end("t1");
        check("t1_pass_count", 32'(pass_cnt), 32'd1);

        // Data bit 5 at addr 2, parity[4] at addr 1, data bits 0+1 at addr 3
        mem[2] = golden[2] ^ 16'h0020;
        mem[1] = golden[1] ^ 16'h8000;
        mem[3] = golden[3] ^ 16'h0003;
        plan_pass();
        wait_pass("t234");
        check_end("t234");
        check("t234_uncorr_addr3", 32'(uncorr_addr), 32'd3);
        check("t2_restored", 32'(mem[2]), 32'(golden[2]));
        check("t3_restored", 32'(mem[1]), 32'(golden[1]));

        // Random error patterns and arbiter behaviour; counters reach saturation
        for (int i = 0; i < 12; i++) begin
            gnt_pct = $urandom_range(30, 100);
            for (int a = 0; a < int'(DEPTH); a++)
                mem[a] = golden[a] ^ flips(int'($urandom_range(0, 2)));
            plan_pass();
            wait_pass("rand");
            check_end("rand");
        end

        // Read stalled by the arbiter, then core overwrites the word under write-back
        gnt_pct = 100;
        for (int a = 0; a < int'(DEPTH); a++) mem[a] = golden[a];
        mem[2]    = golden[2] ^ flips(1);
        block_all = 1'b1;
        block_wr  = 1'b1;
        plan_pass();
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (mem_req) seen = 1'b1;
            end
            check("t5_rd_req_seen", 32'(seen), 32'd1);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t5_stall_req",  32'(mem_req),  32'd1);
            check("t5_stall_addr", 32'(mem_addr), 32'd0);
        end
        block_all = 1'b0;
        wait_write("t5", AW'(2));
        @(posedge clk);
        #2;
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = AW'(2);
        golden[2]    = encode(11'($urandom));
        mem[2]       = golden[2];
        if (exp_wr_q.size() != 0) wr_item = exp_wr_q.pop_front();
        @(posedge clk);
        #2 cpu_wr_valid = 1'b0;
        @(negedge clk);
        check("t5_write_dropped", 32'(mem_req), 32'd0);
        block_wr = 1'b0;
        wait_pass("t5");
        check_end("t5");
        check("t5_core_word_kept", 32'(mem[2]), 32'(golden[2]));

        // Reset while a write-back is pending
        for (int a = 0; a < int'(DEPTH); a++) mem[a] = golden[a];
        mem[1]   = golden[1] ^ flips(1);
        block_wr = 1'b1;
        plan_pass();
        wait_write("t6", AW'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_mem_req",      32'(mem_req),      32'd0);
        check("t6_busy",         32'(busy),         32'd0);
        check("t6_corr_count",   32'(corr_count),   32'd0);
        check("t6_uncorr_count", 32'(uncorr_count), 32'd0);
        check("t6_uncorr_valid", 32'(uncorr_valid), 32'd0);
        exp_wr_q.delete();
        exp_corr = 0;
        exp_unc  = 0;
        exp_uv   = 1'b0;
        exp_ua   = '0;
        block_wr = 1'b0;
        plan_pass();
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_pass("t6");
        check_end("t6");
        check("t6_restored", 32'(mem[1]), 32'(golden[1]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
